// File: rtl/chunked_addsub_seq.sv
// Sequential W-bit adder/subtractor that pushes one N-bit chunk per cycle
// through a single shared adder. Optional `zero` flag: CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN.
module chunked_addsub_seq #(
  parameter int N      = 8,
  parameter int CHUNKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_sub,
  input  logic [N*CHUNKS-1:0] a,
  input  logic [N*CHUNKS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [N*CHUNKS-1:0] result,
  output logic                cout,
  output logic                overflow
`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
  ,
  output logic                zero
`endif
);

  localparam int W     = N * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [W-1:0]     a_q, b_q;
  logic             load;

  logic [N-1:0]     chunk_a, chunk_b;
  logic [N:0]       chunk_sum;
  logic             msb_cin;
  logic             last_chunk;

  // Shared chunk adder; b_q already holds ~b for subtraction, carry_q the +1.
  always_comb begin
    chunk_a    = a_q[idx_q*N +: N];
    chunk_b    = b_q[idx_q*N +: N];
    chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{N{1'b0}}, carry_q};
    msb_cin    = chunk_a[N-1] ^ chunk_b[N-1] ^ chunk_sum[N-1];
    last_chunk = (idx_q == IDX_W'(CHUNKS - 1));
  end

`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;
`endif

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    load     = 1'b0;
`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          carry_d = op_sub;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // NOTE: blocking assignments here, so the zero test below sees the
        // freshly merged chunk; registers themselves only use <=.
        result_d[idx_q*N +: N] = chunk_sum[N-1:0];
        carry_d                = chunk_sum[N];
        idx_d                  = idx_q + IDX_W'(1);
        if (last_chunk) begin
          idx_d   = '0;
          cout_d  = chunk_sum[N];
          ovf_d   = msb_cin ^ chunk_sum[N];
          state_d = DONE;
`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
          zero_d  = (result_d == '0);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: operand holding registers are deliberately not reset; they are only
  // read in RUN, which is always entered through a load.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= a;
      b_q <= op_sub ? ~b : b;
    end
  end

`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end
  assign zero = zero_q;
`endif

  // Status outputs decode registered state only.
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Directed, table-driven bench for chunked_addsub_seq (N=8, CHUNKS=4), plus
// hand-written sequences for ignored starts, back-to-back starts and mid-run reset.
module tb_chunked_addsub_seq;

  localparam int N = 8;
  localparam int CHUNKS = 4;
  localparam int W = N * CHUNKS;
  localparam int BUDGET = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  chunked_addsub_seq #(.N(N), .CHUNKS(CHUNKS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a request at the falling edge; it is accepted at the next rising edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top);
    @(negedge clk);
    a = ta; b = tb_; op_sub = top; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns edges until done and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < BUDGET) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_results(input string tag, input logic [W-1:0] er,
                               input logic ec, input logic eo);
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " result"}, result, er);
    check({tag, " cout"}, cout, ec);
    check({tag, " overflow"}, overflow, eo);
`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
    check({tag, " zero"}, zero, er == '0);
`endif
  endtask

  initial begin
    int lat, bc, extra_busy, extra_done;

    vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1]  = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4]  = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[9]  = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[10] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
    vecs[11] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'h0);
    check("reset cout", cout, 1'b0);
    check("reset overflow", overflow, 1'b0);
`ifdef CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN
    check("reset zero", zero, 1'b0);
`endif

    // First start accepted at the first rising edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h000000FF; b = 32'h00000001; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first start busy", busy, 1'b1);
    wait_done(lat, bc);
    check("first start latency", lat, 4);
    check_results("first start", 32'h00000100, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_done(lat, bc);
      check($sformatf("v%0d latency", i), lat, 4);
      check($sformatf("v%0d busy cycles", i), bc, 4);
      check_results($sformatf("v%0d", i), vecs[i].res, vecs[i].cout, vecs[i].ovf);
      @(posedge clk);
      #1;
      check($sformatf("v%0d done pulse width", i), done, 1'b0);
      check($sformatf("v%0d held result", i), result, vecs[i].res);
    end

    // Start with new operands during RUN cycle 2 is ignored.
    issue(32'h00000010, 32'h00000020, 1'b0);
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000001; op_sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'h0; b = 32'h0;
    wait_done(lat, bc);
    check("ignored start latency", lat, 3);
    check_results("ignored start", 32'h00000030, 1'b0, 1'b0);
    extra_busy = 0;
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (busy) extra_busy++;
      if (done) extra_done++;
    end
    check("ignored start extra busy", extra_busy, 0);
    check("ignored start extra done", extra_done, 0);

    // Start held during DONE begins the next RUN immediately.
    issue(32'h00000001, 32'h00000002, 1'b0);
    wait_done(lat, bc);
    check_results("b2b first", 32'h00000003, 1'b0, 1'b0);
    a = 32'h00000100; b = 32'h00000001; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy next cycle", busy, 1'b1);
    check("b2b done dropped", done, 1'b0);
    wait_done(lat, bc);
    check("b2b second latency", lat, 4);
    check_results("b2b second", 32'h00000101, 1'b0, 1'b0);

    // Reset during RUN cycle 2 clears everything at once and suppresses done.
    issue(32'h11223344, 32'h01010101, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", busy, 1'b0);
    check("mid reset done", done, 1'b0);
    check("mid reset result", result, 32'h0);
    check("mid reset cout", cout, 1'b0);
    check("mid reset overflow", overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra_busy = 0;
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (busy) extra_busy++;
      if (done) extra_done++;
    end
    check("post reset busy", extra_busy, 0);
    check("post reset done", extra_done, 0);
    issue(32'h11223344, 32'h01010101, 1'b0);
    wait_done(lat, bc);
    check("post reset latency", lat, 4);
    check_results("post reset", 32'h12233445, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/chunked_addsub_seq.md
CHUNKED_ADDSUB_SEQ -- requirements
Module: chunked_addsub_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning the chunk width in bits (legal N >= 1).
REQ-002 SHALL have parameter CHUNKS, default 4, meaning the number of chunks per operand (legal CHUNKS >= 1); operand width W = N*CHUNKS.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port `clk`, input, width 1: the single clock, rising edge active.
REQ-005 SHALL have port `rst_n`, input, width 1: asynchronous active-low reset.
REQ-006 SHALL have port `start`, input, width 1: request to begin an operation.
REQ-007 SHALL have port `op_sub`, input, width 1: 0 selects a+b, 1 selects a-b; sampled together with `start`.
REQ-008 SHALL have ports `a` and `b`, input, width W: the operands; sampled together with `start`.
REQ-009 SHALL have port `busy`, output, width 1: high while chunks are being processed.
REQ-010 SHALL have port `done`, output, width 1: one-cycle completion pulse.
REQ-011 SHALL have port `result`, output, width W: the sum or difference.
REQ-012 SHALL have port `cout`, output, width 1: final carry out; for subtraction, 1 means no borrow.
REQ-013 SHALL have port `overflow`, output, width 1: two's-complement signed overflow of the W-bit operation.

Function
REQ-014 SHALL use exactly one shared N-bit adder datapath for all chunks; subtraction is formed as a + ~b + 1.
REQ-015 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 IDLE: on `start`=1 at edge T, SHALL latch a, b and op_sub, set chunk index to 0, set carry to op_sub, and go to RUN.
REQ-017 RUN: at each edge, SHALL process chunk idx (bits idx*N+N-1 : idx*N) with the current carry.
- The chunk sum is written into `result`.
- The carry register takes the chunk carry out.
- idx increments by 1.
REQ-018 RUN SHALL last exactly CHUNKS cycles; at edge T+CHUNKS, when chunk CHUNKS-1 is stored, the FSM SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle, with `done`=1.
- If `start`=1 during DONE, the FSM SHALL start a new operation (as in IDLE) and go to RUN.
- Otherwise it SHALL go to IDLE.
REQ-020 `busy` SHALL be 1 exactly in RUN; `done` SHALL be 1 exactly in DONE; both are registered or decoded from state with no combinational path from inputs.
REQ-021 `start` SHALL be ignored during RUN; operand changes during RUN SHALL NOT affect the operation in flight.
REQ-022 `cout` SHALL equal the carry out of chunk CHUNKS-1.
REQ-023 `overflow` SHALL equal the carry into bit W-1 XOR the carry out of bit W-1.
REQ-024 `result`, `cout` and `overflow` SHALL be valid from the cycle `done`=1 and held until the next accepted `start`.
REQ-025 When CHUNKS=1, RUN SHALL last one cycle.

Reset
REQ-026 While `rst_n`=0, the block SHALL immediately force: state IDLE, idx 0, carry 0, `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0.
REQ-027 Reset asserted mid-RUN SHALL discard the partial result; no `done` pulse follows.
REQ-028 The first `start` is accepted at the first rising edge after `rst_n` deasserts.

Configuration
REQ-029 SHALL use macro CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN to compile an extra output port `zero` (width 1) in or out.
- Defined: `zero` is 1 when `result`==0 and is valid under the same rules as `result`; it resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Verification (N=8, CHUNKS=4)
REQ-030 SHALL cover this add: `start` at edge T with a=0x000000FF, b=0x00000001, op_sub=0 -> busy high for 4 cycles, `done` high only in the cycle after edge T+4, result=0x00000100, cout=0, overflow=0.
REQ-031 SHALL cover this subtract: a=0x00000000, b=0x00000001, op_sub=1 -> result=0xFFFFFFFF, cout=0 (borrow), overflow=0.
REQ-032 SHALL cover signed-overflow cases:
- a=0x7FFFFFFF + b=0x00000001 -> result=0x80000000, cout=0, overflow=1.
- a=0x80000000 - b=0x00000001 -> result=0x7FFFFFFF, cout=1, overflow=1.
REQ-033 SHALL cover ignored and back-to-back starts:
- `start` pulsed with new operands mid-RUN -> the first result is unchanged and no extra operation runs.
- `start` held during DONE -> the next RUN begins immediately and `busy` is high the following cycle.
REQ-034 SHALL cover reset mid-operation: `rst_n` low during RUN cycle 2 -> all outputs 0 immediately, no `done`, and a subsequent operation completes correctly.
REQ-035 SHALL cover the configuration macro: with CHUNKED_ADDSUB_SEQ_ZERO_FLAG_EN defined, 0x12345678 - 0x12345678 -> result=0, cout=1, zero=1.
